// File: rtl/color_pkg.sv
// Shared types and helpers for keypad colour entry: FSM states, digit/colour widths,
// and the nibble-insertion helper that places one hex digit MSB-first into the colour word.
package color_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int COLOR_W    = 24;
    localparam int NIBBLE_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Digit 0 lands in bits [23:20], digit 5 in bits [3:0].
    function automatic logic [COLOR_W-1:0] insert_nibble(
        input logic [COLOR_W-1:0]  color,
        input logic [2:0]          idx,
        input logic [NIBBLE_W-1:0] nib
    );
        logic [COLOR_W-1:0] mask;
        logic [COLOR_W-1:0] val;
        int                 sh;
        sh   = (NUM_DIGITS - 1 - int'(idx)) * NIBBLE_W;
        mask = {{(COLOR_W-NIBBLE_W){1'b0}}, {NIBBLE_W{1'b1}}} << sh;
        val  = {{(COLOR_W-NIBBLE_W){1'b0}}, nib} << sh;
        return (color & ~mask) | val;
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Saturating inactivity counter with clear/enable; expire is combinational, high on the
// enabled cycle that brings the count to TIMEOUT_CYCLES. No backpressure.
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && !clr && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/color_entry_ctrl.sv
// Keypad entry of a 24-bit RGB colour as six hex digits, tagged with a slot; colour is offered
// 1 clock after the 6th key and held (valid never withdrawn) until color_ready; entries abort on timeout.
module color_entry_ctrl
    import color_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int SLOT_W         = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SLOT_W-1:0]  slot_sel,
    input  logic               key_valid,
    input  logic [3:0]         key_code,
    input  logic               cancel,
    input  logic               color_ready,
    output logic [23:0]        color_out,
    output logic [SLOT_W-1:0]  color_slot,
    output logic               color_valid,
    output logic [23:0]        preview,
    output logic [2:0]         digit_idx,
    output logic               busy,
    output logic               timeout_err
);

    state_t              state_q, state_d;
    logic [COLOR_W-1:0]  preview_q, preview_d;
    logic [COLOR_W-1:0]  color_out_q, color_out_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [SLOT_W-1:0]   color_slot_q, color_slot_d;
    logic                color_valid_q, color_valid_d;
    logic [2:0]          digit_idx_q, digit_idx_d;
    logic                busy_q, busy_d;
    logic                timeout_err_q, timeout_err_d;

    logic                in_entry;
    logic                last_key;
    logic                expire;
    logic [COLOR_W-1:0]  merged;

    assign in_entry = (state_q == ENTRY);
    assign last_key = (digit_idx_q == 3'(NUM_DIGITS - 1));
    assign merged   = insert_nibble(preview_q, digit_idx_q, key_code);

    // Any key, start, cancel or leaving ENTRY restarts the inactivity window.
    idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (!in_entry || key_valid || start || cancel),
        .en    (in_entry && !key_valid),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            preview_q     <= '0;
            color_out_q   <= '0;
            slot_q        <= '0;
            color_slot_q  <= '0;
            color_valid_q <= 1'b0;
            digit_idx_q   <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            preview_q     <= preview_d;
            color_out_q   <= color_out_d;
            slot_q        <= slot_d;
            color_slot_q  <= color_slot_d;
            color_valid_q <= color_valid_d;
            digit_idx_q   <= digit_idx_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // ENTRY priority: cancel > start > key > timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = ENTRY;
            end
            ENTRY: begin
                if (cancel)                     state_d = IDLE;
                else if (start)                 state_d = ENTRY;
                else if (key_valid && last_key) state_d = COMMIT;
                else if (key_valid)             state_d = ENTRY;
                else if (expire)                state_d = IDLE;
            end
            COMMIT: begin
                if (color_valid_q && color_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        preview_d     = preview_q;
        color_out_d   = color_out_q;
        slot_d        = slot_q;
        color_slot_d  = color_slot_q;
        color_valid_d = color_valid_q;
        digit_idx_d   = digit_idx_q;
        timeout_err_d = 1'b0;
        busy_d        = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    preview_d   = '0;
                    digit_idx_d = '0;
                    slot_d      = slot_sel;
                end
            end
            ENTRY: begin
                if (cancel) begin
                    digit_idx_d = '0;
                end else if (start) begin
                    preview_d   = '0;
                    digit_idx_d = '0;
                    slot_d      = slot_sel;
                end else if (key_valid) begin
                    preview_d   = merged;
                    digit_idx_d = digit_idx_q + 3'd1;
                    if (last_key) begin
                        color_out_d   = merged;
                        color_slot_d  = slot_q;
                        color_valid_d = 1'b1;
                    end
                end else if (expire) begin
                    timeout_err_d = 1'b1;
                    digit_idx_d   = '0;
                end
            end
            COMMIT: begin
                if (color_valid_q && color_ready) begin
                    color_valid_d = 1'b0;
                    digit_idx_d   = '0;
                end
            end
            default: ;
        endcase
    end

    assign color_out   = color_out_q;
    assign color_slot  = color_slot_q;
    assign color_valid = color_valid_q;
    assign preview     = preview_q;
    assign digit_idx   = digit_idx_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule
